// File: rtl/switch_bus_arbiter.sv
// Round-robin arbiter driving one-hot bus switch enables with a bounded hold time.
// bus_out/bus_valid are decoded straight from the registered grant vector.
module switch_bus_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   data_in,
  output logic [N_REQ-1:0]         grant,
  output logic [WIDTH-1:0]         bus_out,
  output logic                     bus_valid,
  output logic [$clog2(N_REQ)-1:0] owner
);

  localparam int unsigned OW = $clog2(N_REQ);
  localparam int unsigned HW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t            state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [OW-1:0]     ptr_q, ptr_d;
  logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
  logic [N_REQ-1:0]  others;
  logic [OW-1:0]     nxt;

  function automatic logic [OW-1:0] inc_idx(input logic [OW-1:0] i);
    if (i == OW'(N_REQ - 1)) return '0;
    return i + OW'(1);
  endfunction

  // Scan from the far end down so the candidate closest to start wins last.
  function automatic logic [OW-1:0] pick(input logic [OW-1:0] start,
                                         input logic [N_REQ-1:0] mask);
    logic [OW-1:0] sel;
    logic [OW-1:0] res;
    int unsigned   idx;
    res = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = (32'(start) + (N_REQ - 1 - k)) % N_REQ;
      sel = OW'(idx);
      if (mask[sel]) res = sel;
    end
    return res;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [OW-1:0] i);
    return N_REQ'(1) << i;
  endfunction

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    others     = req & ~onehot(owner_q);
    nxt        = '0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          nxt        = pick(ptr_q, req);
          grant_d    = onehot(nxt);
          owner_d    = nxt;
          hold_cnt_d = HW'(1);
          state_d    = OWNED;
        end
      end
      OWNED: begin
        if (!req[owner_q]) begin
          ptr_d = inc_idx(owner_q);
          if (|req) begin
            nxt        = pick(inc_idx(owner_q), req);
            grant_d    = onehot(nxt);
            owner_d    = nxt;
            hold_cnt_d = HW'(1);
          end else begin
            grant_d    = '0;
            owner_d    = '0;
            hold_cnt_d = '0;
            state_d    = IDLE;
          end
        end else if ((MAX_HOLD != 0) && (hold_cnt_q == HW'(MAX_HOLD)) && (|others)) begin
          ptr_d      = inc_idx(owner_q);
          nxt        = pick(inc_idx(owner_q), others);
          grant_d    = onehot(nxt);
          owner_d    = nxt;
          hold_cnt_d = HW'(1);
        end else if (MAX_HOLD == 0) begin
          if (hold_cnt_q != '1) hold_cnt_d = hold_cnt_q + HW'(1);
        end else if (hold_cnt_q < HW'(MAX_HOLD)) begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  always_comb begin
    bus_out = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) bus_out = bus_out | data_in[i*WIDTH +: WIDTH];
    end
  end

  assign grant     = grant_q;
  assign owner     = owner_q;
  assign bus_valid = |grant_q;

endmodule

// File: tb/tb_switch_bus_arbiter.sv
// Directed bench for switch_bus_arbiter: cycle table plus hand-written corner sequences.
module tb_switch_bus_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] data_in;
  logic [3:0]  grant;
  logic [7:0]  bus_out;
  logic        bus_valid;
  logic [1:0]  owner;

  int checks = 0;
  int errors = 0;

  switch_bus_arbiter #(.N_REQ(4), .WIDTH(8), .MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data_in   (data_in),
    .grant     (grant),
    .bus_out   (bus_out),
    .bus_valid (bus_valid),
    .owner     (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] owner;
    logic [7:0] bus;
    logic       valid;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic add(input logic [3:0] r, input logic [3:0] g, input logic [1:0] o,
                     input logic [7:0] b, input logic v);
    vec_t e;
    e.req = r; e.grant = g; e.owner = o; e.bus = b; e.valid = v;
    tbl.push_back(e);
  endtask

  initial begin
    logic [3:0] seen;

    // requester data: 0->11, 1->22, 2->A5, 3->44
    data_in = {8'h44, 8'hA5, 8'h22, 8'h11};
    rst = 1'b0;
    req = '0;

    // Reset holds everything at zero even with all requests up
    rst = 1'b1;
    req = 4'b1111;
    #12;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_bus", 32'(bus_out), 32'h0);
    chk("rst_valid", 32'(bus_valid), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("first_grant", 32'(grant), 32'h1);
    chk("first_bus", 32'(bus_out), 32'h11);

    // Lone requester keeps the bus for 20 cycles
    do_reset();
    req = 4'b0100;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("single_grant", 32'(grant), 32'h4);
      chk("single_bus", 32'(bus_out), 32'hA5);
      chk("single_owner", 32'(owner), 32'h2);
    end

    // Cycle-by-cycle table from a fresh reset
    add(4'b0100, 4'b0100, 2'd2, 8'hA5, 1'b1);
    add(4'b0100, 4'b0100, 2'd2, 8'hA5, 1'b1);
    add(4'b0100, 4'b0100, 2'd2, 8'hA5, 1'b1);
    add(4'b0100, 4'b0100, 2'd2, 8'hA5, 1'b1);
    add(4'b0100, 4'b0100, 2'd2, 8'hA5, 1'b1);
    add(4'b0100, 4'b0100, 2'd2, 8'hA5, 1'b1);
    add(4'b0000, 4'b0000, 2'd0, 8'h00, 1'b0);
    add(4'b1001, 4'b1000, 2'd3, 8'h44, 1'b1);
    add(4'b1001, 4'b1000, 2'd3, 8'h44, 1'b1);
    add(4'b1001, 4'b1000, 2'd3, 8'h44, 1'b1);
    add(4'b1001, 4'b1000, 2'd3, 8'h44, 1'b1);
    add(4'b1001, 4'b0001, 2'd0, 8'h11, 1'b1);
    add(4'b0011, 4'b0001, 2'd0, 8'h11, 1'b1);
    add(4'b0011, 4'b0001, 2'd0, 8'h11, 1'b1);
    add(4'b0011, 4'b0001, 2'd0, 8'h11, 1'b1);
    add(4'b0011, 4'b0010, 2'd1, 8'h22, 1'b1);
    add(4'b0011, 4'b0010, 2'd1, 8'h22, 1'b1);
    add(4'b0011, 4'b0010, 2'd1, 8'h22, 1'b1);
    add(4'b0011, 4'b0010, 2'd1, 8'h22, 1'b1);
    add(4'b0011, 4'b0001, 2'd0, 8'h11, 1'b1);
    add(4'b1010, 4'b0010, 2'd1, 8'h22, 1'b1);
    add(4'b1000, 4'b1000, 2'd3, 8'h44, 1'b1);
    add(4'b0000, 4'b0000, 2'd0, 8'h00, 1'b0);
    add(4'b0110, 4'b0010, 2'd1, 8'h22, 1'b1);
    add(4'b0000, 4'b0000, 2'd0, 8'h00, 1'b0);

    do_reset();
    foreach (tbl[i]) begin
      req = tbl[i].req;
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_grant", i), 32'(grant), 32'(tbl[i].grant));
      chk($sformatf("tbl%0d_owner", i), 32'(owner), 32'(tbl[i].owner));
      chk($sformatf("tbl%0d_bus", i), 32'(bus_out), 32'(tbl[i].bus));
      chk($sformatf("tbl%0d_valid", i), 32'(bus_valid), 32'(tbl[i].valid));
    end

    // Full load: every requester served within 4*MAX_HOLD cycles, never idle
    do_reset();
    req = 4'b1111;
    seen = '0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      chk("load_onehot", 32'($onehot(grant)), 32'h1);
      seen = seen | grant;
      if (i == 4)  chk("load_c4", 32'(grant), 32'h2);
      if (i == 8)  chk("load_c8", 32'(grant), 32'h4);
      if (i == 12) chk("load_c12", 32'(grant), 32'h8);
    end
    chk("load_all_served", 32'(seen), 32'hF);

    // Async reset between edges drops grant and bus immediately
    do_reset();
    req = 4'b0010;
    @(posedge clk); #1;
    chk("async_pre_grant", 32'(grant), 32'h2);
    #2 rst = 1'b1;
    #1;
    chk("async_grant", 32'(grant), 32'h0);
    chk("async_bus", 32'(bus_out), 32'h0);
    chk("async_valid", 32'(bus_valid), 32'h0);
    @(negedge clk) rst = 1'b0;
    req = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
